// File: rtl/uart_pkg.sv
// UART shared definitions: parity mode encodings, RX check FSM states, parity helper.
// Pure declarations; no latency.
// No flow control.
package uart_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    // Widest legal frame; narrower words are zero-extended, which leaves XOR parity unchanged.
    localparam int PAR_WORD_W = 9;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_ACCUM    = 2'd1,
        RX_WAIT_PAR = 2'd2
    } rx_state_t;

    function automatic logic parity_of(input logic [PAR_WORD_W-1:0] word,
                                       input logic [1:0]            mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^word;
            PAR_ODD:  p = ~^word;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_parity_err_cnt.sv
// Saturating parity error counter, built only when UART_PARITY_ERR_COUNT_EN is defined.
// Latency: count reflects an inc or clr on the following cycle.
// No backpressure; clr wins over a simultaneous inc.
`ifdef UART_PARITY_ERR_COUNT_EN
module uart_parity_err_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule
`endif

// File: rtl/uart_parity_unit.sv
// UART parity generator (TX, parallel) and serial checker (RX); optional error counter via UART_PARITY_ERR_COUNT_EN.
// Latency: par_bit one cycle after data_valid; chk_done/par_err one cycle after rx_par_valid.
// No backpressure: every strobe is accepted in the cycle it is presented.
module uart_parity_unit
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  par_en,
    input  logic [1:0]            par_mode,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  par_bit,
    input  logic                  rx_start,
    input  logic                  rx_bit_valid,
    input  logic                  rx_bit,
    input  logic                  rx_par_valid,
    input  logic                  rx_par,
    output logic                  busy,
    output logic                  chk_done,
    output logic                  par_err
`ifdef UART_PARITY_ERR_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  err_count,
    input  logic                  err_clr
`endif
);

    localparam int              BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > PAR_WORD_W) begin : g_bad_data_width
            $error("uart_parity_unit: DATA_WIDTH must be 5..9");
        end
        if (CNT_WIDTH < 1) begin : g_bad_cnt_width
            $error("uart_parity_unit: CNT_WIDTH must be at least 1");
        end
    endgenerate

    // TX parity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit <= 1'b0;
        end else if (data_valid && par_en) begin
            par_bit <= parity_of(PAR_WORD_W'(p_data), par_mode);
        end
    end

    // RX check
    rx_state_t              state_q, state_d;
    logic                   acc_q, acc_d;
    logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]             mode_q, mode_d;
    logic                   done_d, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RX_IDLE;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= PAR_EVEN;
            chk_done <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            chk_done <= done_d;
            par_err  <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // A new frame start overrides any other strobe and silently drops the frame in flight.
        if (rx_start && par_en) begin
            state_d = RX_ACCUM;
            acc_d   = 1'b0;
            cnt_d   = '0;
            mode_d  = par_mode;
        end else begin
            case (state_q)
                RX_IDLE: begin
                end
                RX_ACCUM: begin
                    if (rx_bit_valid) begin
                        acc_d = acc_q ^ rx_bit;
                        cnt_d = cnt_q + BIT_CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_d = RX_WAIT_PAR;
                        end
                    end
                end
                RX_WAIT_PAR: begin
                    if (rx_par_valid) begin
                        state_d = RX_IDLE;
                        done_d  = 1'b1;
                        err_d   = rx_par ^ parity_of(PAR_WORD_W'(acc_q), mode_q);
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign busy = (state_q != RX_IDLE);

`ifdef UART_PARITY_ERR_COUNT_EN
    uart_parity_err_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (par_err),
        .clr   (err_clr),
        .count (err_count)
    );
`endif

endmodule

// File: tb/tb_uart_parity_unit.sv
// Directed + randomized bench for uart_parity_unit with a popcount-based parity reference.
// Error counter checks are active when UART_PARITY_ERR_COUNT_EN is defined.
module tb_uart_parity_unit;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          par_en;
    logic [1:0]    par_mode;
    logic          data_valid;
    logic [DW-1:0] p_data;
    logic          par_bit;
    logic          rx_start;
    logic          rx_bit_valid;
    logic          rx_bit;
    logic          rx_par_valid;
    logic          rx_par;
    logic          busy;
    logic          chk_done;
    logic          par_err;
`ifdef UART_PARITY_ERR_COUNT_EN
    logic [CW-1:0] err_count;
    logic          err_clr;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int mcnt   = 0;
    logic tx_exp = 1'b0;

    uart_parity_unit #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .par_en       (par_en),
        .par_mode     (par_mode),
        .data_valid   (data_valid),
        .p_data       (p_data),
        .par_bit      (par_bit),
        .rx_start     (rx_start),
        .rx_bit_valid (rx_bit_valid),
        .rx_bit       (rx_bit),
        .rx_par_valid (rx_par_valid),
        .rx_par       (rx_par),
        .busy         (busy),
        .chk_done     (chk_done),
        .par_err      (par_err)
`ifdef UART_PARITY_ERR_COUNT_EN
        ,
        .err_count    (err_count),
        .err_clr      (err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference parity from the mode rules: count the ones in the word.
    function automatic logic ref_parity(input logic [DW-1:0] w, input logic [1:0] m);
        int ones;
        ones = $countones(w);
        case (m)
            2'd0:    return (ones % 2) == 1;
            2'd1:    return (ones % 2) == 0;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx(input logic en, input logic [1:0] mode, input logic [DW-1:0] data, input string tag);
        data_valid = 1'b1;
        par_en     = en;
        par_mode   = mode;
        p_data     = data;
        if (en) tx_exp = ref_parity(data, mode);
        tick();
        data_valid = 1'b0;
        check(tag, par_bit, tx_exp);
    endtask

    task automatic rx_begin(input logic [1:0] mode);
        par_en   = 1'b1;
        par_mode = mode;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        check("rx_busy_start", busy, 1);
    endtask

    task automatic rx_bits(input logic [DW-1:0] word, input bit noisy);
        for (int i = 0; i < DW; i++) begin
            if (noisy) repeat ($urandom_range(0, 2)) tick();
            rx_bit_valid = 1'b1;
            rx_bit       = word[i];
            rx_par_valid = noisy ? 1'($urandom) : 1'b0;
            rx_par       = 1'($urandom);
            if (noisy) begin
                par_mode = 2'($urandom);
                par_en   = 1'($urandom);
            end
            tick();
            rx_bit_valid = 1'b0;
            rx_par_valid = 1'b0;
            check("rx_no_early_done", chk_done, 0);
        end
        if (noisy) begin
            rx_bit_valid = 1'b1;
            rx_bit       = 1'($urandom);
            tick();
            rx_bit_valid = 1'b0;
        end
        check("rx_busy_wait_par", busy, 1);
    endtask

    task automatic rx_end(input logic rxp, input logic exp_par, input logic clr_at_done);
        logic exp_err;
        exp_err      = (rxp != exp_par);
        rx_par_valid = 1'b1;
        rx_par       = rxp;
        tick();
        rx_par_valid = 1'b0;
        check("rx_chk_done", chk_done, 1);
        check("rx_par_err", par_err, exp_err);
        check("rx_busy_after", busy, 0);
`ifdef UART_PARITY_ERR_COUNT_EN
        err_clr = clr_at_done;
`endif
        tick();
`ifdef UART_PARITY_ERR_COUNT_EN
        err_clr = 1'b0;
`endif
        check("rx_done_one_cycle", chk_done, 0);
        check("rx_err_one_cycle", par_err, 0);
        if (clr_at_done) mcnt = 0;
        else if (exp_err && mcnt < (2**CW - 1)) mcnt++;
`ifdef UART_PARITY_ERR_COUNT_EN
        check("err_count", err_count, mcnt);
`endif
    endtask

    task automatic rx_frame(input logic [1:0] mode, input logic [DW-1:0] word, input logic rxp,
                            input bit noisy, input logic clr_at_done);
        rx_begin(mode);
        rx_bits(word, noisy);
        rx_end(rxp, ref_parity(word, mode), clr_at_done);
    endtask

    initial begin
        rst          = 1'b0;
        par_en       = 1'b0;
        par_mode     = 2'd0;
        data_valid   = 1'b0;
        p_data       = '0;
        rx_start     = 1'b0;
        rx_bit_valid = 1'b0;
        rx_bit       = 1'b0;
        rx_par_valid = 1'b0;
        rx_par       = 1'b0;
`ifdef UART_PARITY_ERR_COUNT_EN
        err_clr      = 1'b0;
`endif
        #3;
        check("rst_par_bit", par_bit, 0);
        check("rst_busy", busy, 0);
        check("rst_chk_done", chk_done, 0);
        check("rst_par_err", par_err, 0);
`ifdef UART_PARITY_ERR_COUNT_EN
        check("rst_err_count", err_count, 0);
`endif
        #9 rst = 1'b1;
        tick();

        // TX modes on 8'hA5 (four ones)
        tx(1'b1, 2'd0, 8'hA5, "tx_even");
        check("tx_even_const", par_bit, 0);
        tx(1'b1, 2'd1, 8'hA5, "tx_odd");
        check("tx_odd_const", par_bit, 1);
        tx(1'b1, 2'd2, 8'hA5, "tx_mark");
        tx(1'b1, 2'd3, 8'hA5, "tx_space");
        tx(1'b0, 2'd2, 8'h01, "tx_gated_hold");
        check("tx_gated_const", par_bit, 0);

        // Randomized TX, including cycles without a strobe
        for (int i = 0; i < 30; i++) begin
            data_valid = 1'($urandom);
            par_en     = 1'($urandom);
            par_mode   = 2'($urandom);
            p_data     = DW'($urandom);
            if (data_valid && par_en) tx_exp = ref_parity(p_data, par_mode);
            tick();
            check("tx_random", par_bit, tx_exp);
        end
        data_valid = 1'b0;

        // Directed RX checks in even mode: bits 1,0,1,1,0,0,0,0 (LSB first)
        rx_frame(2'd0, 8'b0000_1101, 1'b1, 1'b0, 1'b0);
        rx_frame(2'd0, 8'b0000_1101, 1'b0, 1'b0, 1'b0);

        // rx_start while disabled is ignored
        par_en   = 1'b0;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        check("rx_start_gated", busy, 0);

        // Restart after 4 bits, colliding with a bit strobe
        rx_begin(2'd0);
        for (int i = 0; i < 4; i++) begin
            rx_bit_valid = 1'b1;
            rx_bit       = 1'b1;
            tick();
        end
        rx_start = 1'b1;
        par_mode = 2'd1;
        tick();
        rx_start     = 1'b0;
        rx_bit_valid = 1'b0;
        check("restart_no_done", chk_done, 0);
        check("restart_no_err", par_err, 0);
        check("restart_busy", busy, 1);
        rx_bits(8'hFF, 1'b0);
        rx_end(1'b1, 1'b1, 1'b0);

        // Async reset while waiting for the parity bit
        rx_begin(2'd1);
        rx_bits(8'h3C, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_chk_done", chk_done, 0);
        check("arst_par_err", par_err, 0);
        check("arst_par_bit", par_bit, 0);
        tx_exp = 1'b0;
        mcnt   = 0;
        #2 rst = 1'b1;
        tick();
        rx_par_valid = 1'b1;
        rx_par       = 1'b0;
        tick();
        rx_par_valid = 1'b0;
        check("arst_late_par_done", chk_done, 0);
        check("arst_late_par_err", par_err, 0);

        // Randomized frames with mid-frame mode/enable churn and ignored strobes
        for (int i = 0; i < 20; i++) begin
            rx_frame(2'($urandom), DW'($urandom), 1'($urandom), 1'b1, 1'b0);
        end

`ifdef UART_PARITY_ERR_COUNT_EN
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        mcnt    = 0;
        check("err_clr_alone", err_count, 0);
        for (int i = 0; i < 5; i++) rx_frame(2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("err_saturated", err_count, 3);
        rx_frame(2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("err_clr_priority", err_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_parity_unit.md
Name: uart_parity_unit

Overview:
- Parametrised parity generator and checker for the UART datapath.
- TX side: computes a registered parity bit from a parallel word, with four parity modes.
- RX side: accumulates parity serially, bit by bit, as the deserialiser shifts data in. It then checks the received parity bit and flags mismatches with single-cycle pulses.
- Sits between the TX/RX control FSMs and the serialiser/deserialiser.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CNT_WIDTH, 8, width of the parity error counter; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- par_en  in  1  parity enable
- par_mode  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
- data_valid  in  1  TX word strobe
- p_data  in  DATA_WIDTH  TX parallel word
- par_bit  out  1  registered TX parity bit
- rx_start  in  1  start of RX frame; clears the accumulator
- rx_bit_valid  in  1  RX data bit strobe
- rx_bit  in  1  RX data bit
- rx_par_valid  in  1  received-parity-bit strobe
- rx_par  in  1  received parity bit
- busy  out  1  RX check in progress (state not IDLE)
- chk_done  out  1  one-cycle pulse: check complete
- par_err  out  1  one-cycle pulse: parity mismatch
- err_count  out  CNT_WIDTH  saturating error count (optional feature only)
- err_clr  in  1  synchronous clear of err_count (optional feature only)

Behaviour:
- Reset (rst low, async):
  - par_bit, busy, chk_done, par_err = 0.
  - Accumulator and bit counter = 0; FSM = IDLE; err_count = 0.
  - Reset mid-frame aborts the check silently; no pulse is emitted.
- TX path:
  - On a clk edge with data_valid && par_en, par_bit is updated and is valid the next cycle.
  - Parity by mode:
    - even: XOR-reduce of p_data.
    - odd: XNOR-reduce of p_data.
    - mark: 1.
    - space: 0.
  - Otherwise par_bit holds its value.
  - par_mode is sampled only at the data_valid edge.
- RX FSM states: IDLE, ACCUM, WAIT_PAR.
  - IDLE -> ACCUM: on rx_start && par_en. The FSM clears the accumulator, clears the bit counter, and latches par_mode into mode_q.
  - rx_start while par_en = 0 is ignored.
  - ACCUM: each rx_bit_valid does acc ^= rx_bit and cnt++. When the bit with cnt = DATA_WIDTH-1 is accepted, the FSM moves to WAIT_PAR.
  - ACCUM: rx_par_valid is ignored (early strobe, no error).
  - WAIT_PAR: rx_bit_valid is ignored.
  - WAIT_PAR -> IDLE on rx_par_valid:
    - Expected parity: even -> acc, odd -> ~acc, mark -> 1, space -> 0.
    - chk_done pulses high the cycle after rx_par_valid is sampled.
    - par_err pulses in the same cycle if rx_par != expected.
- Priority: rx_start (with par_en high) in ACCUM or WAIT_PAR restarts the frame.
  - It wins over a simultaneous rx_bit_valid or rx_par_valid.
  - No done/err pulse is produced for the aborted frame.
- Mid-frame changes: changes to par_en or par_mode after rx_start do not affect the frame in progress (mode_q is used).
- Independence: TX and RX paths are independent. data_valid and RX strobes may coincide in the same cycle.
- Width: bit counter is $clog2(DATA_WIDTH+1) bits and never wraps; the FSM leaves ACCUM at DATA_WIDTH.
- busy is 1 in ACCUM and WAIT_PAR, and 0 in IDLE.

Optional Feature:
- Macro: UART_PARITY_ERR_COUNT_EN.
- When defined:
  - err_count and err_clr exist.
  - err_count increments on each par_err pulse and saturates at 2^CNT_WIDTH-1.
  - err_clr zeroes the counter next cycle and has priority over a simultaneous increment.
- When undefined:
  - Neither port exists and no counter logic is built.
  - All other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - the par_mode encodings PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11;
  - the RX FSM state typedef;
  - a parity function (word, mode) -> bit, reused by TX and by the RX expected-value logic.
- One natural sub-module: uart_parity_err_cnt, the saturating counter, instantiated only under the macro.

Test Plan:
- TX modes: DATA_WIDTH=8, p_data=8'hA5, data_valid pulse per mode -> par_bit = 0 even, 1 odd, 1 mark, 0 space, each one cycle after the strobe.
- TX gating: par_en=0 with data_valid=1, p_data=8'h01 -> par_bit holds its prior value.
- RX check, even mode: rx_start, then bits 1,0,1,1,0,0,0,0, then rx_par=1 -> chk_done=1, par_err=0 the next cycle, busy=0 after. Repeat with rx_par=0 -> par_err=1.
- RX restart: after 4 bits, assert rx_start simultaneously with rx_bit_valid -> no pulses. Then feed a fresh 8 bits of 8'hFF plus rx_par=1 in odd mode -> chk_done=1, par_err=0.
- Async reset mid-WAIT_PAR: rst low -> busy=0, chk_done=0, par_err=0 immediately; later rx_par_valid gives no pulse.
- With UART_PARITY_ERR_COUNT_EN and CNT_WIDTH=2: 5 forced errors -> err_count = 3 (saturated). Then err_clr together with a sixth error -> err_count = 0.
